// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD running-sum datapath.
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ADD_ONES = 2'd1,
      ADD_TENS = 2'd2
   } state_t;

   localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add: a + b + ci, corrected back into 0..9
// with a decimal carry out whenever the binary sum exceeds nine.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_t a,
   input  bcd_t b,
   input  logic ci,
   output bcd_t s,
   output logic co
);

   logic [4:0] raw;
   logic [4:0] adj;

   // Binary add, then subtract ten when the result leaves the BCD range
   always_comb begin
      raw = {1'b0, a} + {1'b0, b} + {4'd0, ci};
      adj = raw - 5'd10;
      if (raw > {1'b0, BCD_MAX}) begin
         s  = adj[3:0];
         co = 1'b1;
      end else begin
         s  = raw[3:0];
         co = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_accumulator.sv
// Two-digit BCD running-sum register. A synchronized, edge-detected key press
// adds one validated decimal digit into a stored 00..99 total over two cycles
// (ones then tens), with sticky overflow and bad-digit flags.
module bcd_accumulator
   import bcd_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] add_digit,
   input  logic       add_key,
   input  logic       clr,
   output logic [3:0] acc_ones,
   output logic [3:0] acc_tens,
   output logic       ovf,
   output logic       err,
   output logic       busy
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   k_s;
   logic                   k_prev;
   logic                   req;

   state_t state;
   bcd_t   op;
   logic   carry;

   bcd_t   add_a;
   bcd_t   add_b;
   logic   add_ci;
   bcd_t   add_s;
   logic   add_co;

   assign k_s = sync[SYNC_STAGES-1];
   assign req = k_s & ~k_prev;

   // Metastability chain for the asynchronous key plus one-cycle delay for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync   <= '0;
         k_prev <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], add_key};
         k_prev <= k_s;
      end
   end

   // One shared digit adder: ones step adds the operand, tens step adds the carry
   always_comb begin
      add_a  = acc_ones;
      add_b  = op;
      add_ci = 1'b0;
      if (state == ADD_TENS) begin
         add_a  = acc_tens;
         add_b  = '0;
         add_ci = carry;
      end
   end

   bcd_digit_add u_digit_add (
      .a  (add_a),
      .b  (add_b),
      .ci (add_ci),
      .s  (add_s),
      .co (add_co)
   );

   // Control FSM and total registers; clr overrides any add in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         op       <= '0;
         carry    <= 1'b0;
         acc_ones <= '0;
         acc_tens <= '0;
         ovf      <= 1'b0;
         err      <= 1'b0;
      end else if (clr) begin
         state    <= IDLE;
         busy     <= 1'b0;
         acc_ones <= '0;
         acc_tens <= '0;
         ovf      <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (add_digit > BCD_MAX) begin
                     err <= 1'b1;
                  end else begin
                     op    <= add_digit;
                     err   <= 1'b0;
                     state <= ADD_ONES;
                     busy  <= 1'b1;
                  end
               end
            end
            ADD_ONES: begin
               acc_ones <= add_s;
               carry    <= add_co;
               state    <= ADD_TENS;
            end
            ADD_TENS: begin
               acc_tens <= add_s;
               if (add_co) ovf <= 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bcd_accumulator.md
# bcd_accumulator

Two-digit BCD running-sum register that sits directly upstream of the team's BCD adder and seven-segment display path. It takes one decimal digit from the switches per key press, validates it, and adds it into a stored 00–99 total. It drives the tens/ones BCD digits consumed by the `seven_segment` decoders, and keeps sticky overflow and error flags for the LEDs.

## Interface
- SYNC_STAGES, 2, number of flops in the `add_key` synchronizer (≥2).
- Clock  in  1  system clock (CLOCK_50 on the board).
- Reset  in  1  asynchronous, active-high; clears all state.
- add_digit  in  4  BCD operand from SW[3:0]; sampled only when a request is accepted.
- add_key  in  1  raw, asynchronous add request (debounced key, active-high level).
- clr  in  1  synchronous clear of total and flags.
- acc_ones  out  4  BCD ones digit of total.
- acc_tens  out  4  BCD tens digit of total.
- ovf  out  1  sticky: total wrapped past 99.
- err  out  1  sticky: last request carried a non-BCD digit (>9).
- busy  out  1  add in progress; requests are dropped while high.

## Operation
- `add_key` passes through SYNC_STAGES flops to `k_s`. `k_prev` is `k_s` delayed one cycle. `req = k_s & ~k_prev`, one cycle per rising edge. A key held high yields exactly one request.
- FSM states: IDLE, ADD_ONES, ADD_TENS. Reset state is IDLE.
- IDLE, `req` with `add_digit` > 9: set `err`, keep the total unchanged, stay in IDLE.
- IDLE, `req` with `add_digit` ≤ 9: latch `add_digit` into `op`, clear `err`, go to ADD_ONES.
- ADD_ONES: `s = acc_ones + op` in 5 bits (0–18).
  - If s > 9: `acc_ones ← s − 10`, carry ← 1.
  - Otherwise: `acc_ones ← s`, carry ← 0.
  - Go to ADD_TENS.
- ADD_TENS: `acc_tens ← acc_tens + carry` using the same BCD rule. If `acc_tens = 9` and carry = 1: `acc_tens ← 0` and `ovf ← 1`. Go to IDLE.
- `busy` = 1 in ADD_ONES and ADD_TENS. A `req` seen outside IDLE is discarded and is not queued.
- `clr` has priority over everything except Reset, in every state:
  - `acc_ones`, `acc_tens`, `ovf`, `err` ← 0.
  - FSM ← IDLE.
  - A pending ADD_TENS update is abandoned.
- `clr` and `req` in the same cycle: clr wins and the request is lost.
- `ovf` clears only on Reset or `clr`. `err` clears on Reset, `clr`, or an accepted valid request.
- The total never holds a non-BCD digit.

## Timing
- Reset values: `acc_ones` = 0, `acc_tens` = 0, `ovf` = 0, `err` = 0, `busy` = 0, synchronizer and `k_prev` = 0.
- Reset acts immediately (asynchronous), including mid-add.
- `req` is high in cycle R. `op` is latched and `busy` rises at edge R+1.
- `acc_ones` is updated at edge R+2.
- `acc_tens` and `ovf` are updated at edge R+3; `busy` falls at the same edge.
- Minimum spacing between accepted requests is 3 cycles.
- `err` is updated at edge R+1.
- From a raw `add_key` rise to the final total: SYNC_STAGES + 3 edges, plus up to 1 edge of synchronizer uncertainty.
- Between edges R+2 and R+3 the outputs may show the new ones digit with the old tens digit. The consumer must not depend on them before `busy` falls.
- All outputs are registered.

## Structure
- Shared package `bcd_pkg`:
  - state enum {IDLE, ADD_ONES, ADD_TENS}
  - 4-bit `bcd_t` typedef
  - constant `BCD_MAX = 9`
- Sub-module `bcd_digit_add`: combinational single-digit add (`a`, `b`, `ci` → `s`, `co`) with the >9 correction. Used in both the ADD_ONES and ADD_TENS steps.
- The top-level holds the synchronizer, edge detector, FSM and registers.

## Test plan
- Reset asserted at any time -> all outputs 0 in the same cycle; `busy` 0.
- Add 7, then add 5 (each a rising `add_key` edge) -> total 07, then 12; `ovf` 0; `busy` high for exactly 2 cycles per add.
- `add_digit = 4'b1100` with a key edge -> `err` 1 and total unchanged; then add 3 -> `err` 0 and total +3.
- Accumulate to 99, then add 1 -> 00 with `ovf` 1; add 2 -> 02 with `ovf` still 1; pulse `clr` -> 00 with `ovf` 0.
- Hold `add_key` high for 50 cycles with digit 4 -> exactly one add (total +4). Also re-pulse the key while `busy` -> the second pulse is dropped.
- Assert `clr` in the ADD_TENS cycle of 95+5 -> total 00, `ovf` 0, FSM in IDLE, no late tens update. Assert Reset mid-ADD_ONES -> immediate zero.
